// File: rtl/vadd_pkg.sv
// Shared definitions for the word-serial wide adder: FSM encoding and word width.
package vadd_pkg;
    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/VRCA_64.sv
// 64-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module VRCA_64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        ci_i,
    output logic [63:0] s_o,
    output logic        co_o
);
    logic [64:0] c;

    assign c[0] = ci_i;

    for (genvar i = 0; i < 64; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o = c[64];
endmodule

// File: rtl/vadd_seq_128.sv
// Word-serial add/subtract of N_WORDS x 64-bit operands through a single 64-bit adder,
// one word per cycle, with a valid/ready handshake on both sides.
module vadd_seq_128
    import vadd_pkg::*;
#(
    parameter int N_WORDS = 2
) (
    input  logic                        in_CLK,
    input  logic                        in_RSTN,
    input  logic                        in_VALID,
    output logic                        out_READY,
    input  logic [WORD_W*N_WORDS-1:0]   in_A,
    input  logic [WORD_W*N_WORDS-1:0]   in_B,
    input  logic                        in_CI,
    input  logic                        in_SUB,
    output logic                        out_VALID,
    input  logic                        in_READY,
    output logic [WORD_W*N_WORDS-1:0]   out_S,
    output logic                        out_CO,
    output logic                        out_OVF
);
    localparam int W  = WORD_W * N_WORDS;
    localparam int KW = $clog2(N_WORDS + 1);

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
    logic            carry_q, carry_d;

    logic [WORD_W-1:0] a_w, b_w, sum_w;
    logic              co_w;

    // Word k of each captured operand feeds the shared adder.
    always_comb begin
        a_w = '0;
        b_w = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (k_q == KW'(w)) begin
                a_w = a_q[w*WORD_W +: WORD_W];
                b_w = b_q[w*WORD_W +: WORD_W];
            end
        end
    end

    VRCA_64 u_rca (
        .a_i  (a_w),
        .b_i  (b_w),
        .ci_i (carry_q),
        .s_o  (sum_w),
        .co_o (co_w)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_VALID) begin
                    // Subtraction is A + ~B + 1, so B is inverted once at capture.
                    a_d     = in_A;
                    b_d     = in_SUB ? ~in_B : in_B;
                    carry_d = in_SUB ? 1'b1 : in_CI;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int w = 0; w < N_WORDS; w++) begin
                    if (k_q == KW'(w)) s_d[w*WORD_W +: WORD_W] = sum_w;
                end
                carry_d = co_w;
                k_d     = k_q + KW'(1);
                if (k_q == KW'(N_WORDS - 1)) state_d = DONE;
            end
            DONE: begin
                if (in_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_CLK) begin
        if (!in_RSTN) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
        end
    end

    assign out_READY = (state_q == IDLE);
    assign out_VALID = (state_q == DONE);
    assign out_S     = s_q;
    assign out_CO    = carry_q;
    assign out_OVF   = (a_q[W-1] == b_q[W-1]) && (s_q[W-1] != a_q[W-1]);
endmodule

// File: tb/tb_vadd_seq_128.sv
// Directed and randomized checks of vadd_seq_128 at N_WORDS=2 and N_WORDS=1.
module tb_vadd_seq_128;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // N_WORDS=2 instance
    logic         v2, rdy2, ov2, ir2, ci2, sub2, co2, ovf2;
    logic [127:0] a2, b2, s2;
    // N_WORDS=1 instance
    logic         v1, rdy1, ov1, ir1, ci1, sub1, co1, ovf1;
    logic [63:0]  a1, b1, s1;

    vadd_seq_128 #(.N_WORDS(2)) dut2 (
        .in_CLK(clk), .in_RSTN(rstn), .in_VALID(v2), .out_READY(rdy2),
        .in_A(a2), .in_B(b2), .in_CI(ci2), .in_SUB(sub2),
        .out_VALID(ov2), .in_READY(ir2), .out_S(s2), .out_CO(co2), .out_OVF(ovf2)
    );

    vadd_seq_128 #(.N_WORDS(1)) dut1 (
        .in_CLK(clk), .in_RSTN(rstn), .in_VALID(v1), .out_READY(rdy1),
        .in_A(a1), .in_B(b1), .in_CI(ci1), .in_SUB(sub1),
        .out_VALID(ov1), .in_READY(ir1), .out_S(s1), .out_CO(co1), .out_OVF(ovf1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full N_WORDS=2 transaction; inputs are scrambled after accept.
    task automatic run2(input string tag, input logic [127:0] a, input logic [127:0] b,
                        input logic ci, input logic sub,
                        input logic [127:0] es, input logic eco, input logic eovf);
        int lat;
        chk({tag, "_rdy_before"}, 128'(rdy2), 128'd1);
        a2 = a; b2 = b; ci2 = ci; sub2 = sub; v2 = 1'b1;
        tick();
        v2 = 1'b0; a2 = ~a; b2 = ~b; ci2 = ~ci; sub2 = ~sub;
        lat = 0;
        while (!ov2 && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'd2);
        chk({tag, "_s"},   s2,          es);
        chk({tag, "_co"},  128'(co2),   128'(eco));
        chk({tag, "_ovf"}, 128'(ovf2),  128'(eovf));
        ir2 = 1'b1;
        tick();
        ir2 = 1'b0;
        chk({tag, "_idle_after"}, 128'({ov2, rdy2}), 128'b01);
    endtask

    logic [127:0] hold_s;
    logic         hold_co, hold_ovf;

    initial begin
        rstn = 1'b0;
        v2 = 0; ir2 = 0; ci2 = 0; sub2 = 0; a2 = '0; b2 = '0;
        v1 = 0; ir1 = 0; ci1 = 0; sub1 = 0; a1 = '0; b1 = '0;
        tick(); tick();
        chk("rst_s",   s2, 128'd0);
        chk("rst_flags", 128'({ov2, co2, ovf2}), 128'd0);
        rstn = 1'b1;
        tick();
        chk("rst_rdy2", 128'(rdy2), 128'd1);
        chk("rst_rdy1", 128'(rdy1), 128'd1);

        // Directed N_WORDS=2 vectors.
        run2("add_xcarry", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
             128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0);
        run2("sub_0m1", 128'd0, 128'd1, 1'b0, 1'b1,
             {128{1'b1}}, 1'b0, 1'b0);
        run2("sub_minov", 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b0, 1'b1,
             128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run2("add_ci_wrap", {128{1'b1}}, 128'd0, 1'b1, 1'b0,
             128'd0, 1'b1, 1'b0);
        run2("add_posov", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
             128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);

        // Backpressure: result held while the consumer stalls, new requests ignored.
        a2 = 128'd5; b2 = 128'd7; ci2 = 0; sub2 = 0; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        tick(); tick();
        chk("bp_valid", 128'(ov2), 128'd1);
        for (int i = 0; i < 5; i++) begin
            v2 = ~v2;
            a2 = 128'(i * 1000 + 17);
            tick();
            chk("bp_s",   s2, 128'd12);
            chk("bp_hs",  128'({ov2, rdy2, co2, ovf2}), 128'b1000);
        end
        v2 = 1'b0;
        ir2 = 1'b1;
        tick();
        ir2 = 1'b0;
        chk("bp_release", 128'({ov2, rdy2}), 128'b01);

        // Reset after word 0 aborts the operation.
        a2 = 128'h3_0000_0000_0000_0003; b2 = 128'd4; ci2 = 0; sub2 = 0; v2 = 1'b1;
        tick();
        v2 = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        chk("rr_s",     s2, 128'd0);
        chk("rr_flags", 128'({ov2, co2, ovf2, rdy2}), 128'b0001);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_novalid", 128'({ov2, rdy2}), 128'b01);
        end
        run2("rr_after", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
             128'h1111_1111_1111_1111_F000_0000_0000_0000, 1'b0, 1'b0,
             128'h1234_5678_9ABC_DF01_EEDC_BA98_7654_3210, 1'b0, 1'b0);

        // N_WORDS=1 directed: latency of one edge.
        begin
            int lat;
            a1 = '1; b1 = '1; ci1 = 1'b1; sub1 = 1'b0; v1 = 1'b1;
            tick();
            v1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
            lat = 0;
            while (!ov1 && lat < 10) begin
                tick();
                lat++;
            end
            chk("n1_lat", 128'(lat), 128'd1);
            chk("n1_s",   128'(s1),  128'hFFFF_FFFF_FFFF_FFFF);
            chk("n1_co",  128'(co1), 128'd1);
            chk("n1_ovf", 128'(ovf1), 128'd0);
            ir1 = 1'b1;
            tick();
            ir1 = 1'b0;
        end

        // N_WORDS=1 randomized traffic against a 65-bit reference sum.
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] ra, rb, bb;
            logic        rci, rsub;
            logic [64:0] ref_sum;
            logic        ref_ovf;
            int          lat;
            repeat ($urandom_range(0, 2)) tick();
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rci = 1'($urandom);
            rsub = 1'($urandom);
            bb = rsub ? ~rb : rb;
            ref_sum = {1'b0, ra} + {1'b0, bb} + 65'(rsub ? 1'b1 : rci);
            ref_ovf = (ra[63] == bb[63]) && (ref_sum[63] != ra[63]);
            a1 = ra; b1 = rb; ci1 = rci; sub1 = rsub; v1 = 1'b1;
            tick();
            v1 = 1'($urandom); a1 = {$urandom, $urandom}; b1 = ~rb; ci1 = ~rci; sub1 = ~rsub;
            lat = 0;
            while (!ov1 && lat < 10) begin
                tick();
                lat++;
            end
            chk("rnd_lat", 128'(lat), 128'd1);
            repeat ($urandom_range(0, 2)) tick();
            chk("rnd_s",   128'(s1), 128'(ref_sum[63:0]));
            chk("rnd_flags", 128'({ov1, co1, ovf1}), 128'({1'b1, ref_sum[64], ref_ovf}));
            v1 = 1'b0;
            ir1 = 1'b1;
            tick();
            ir1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vadd_seq_128.md
VADD_SEQ_128 -- requirements
Module: VADD_SEQ_128

Interface
REQ-001 The block SHALL have parameter N_WORDS, default 2, giving the number of 64-bit words per operand (legal range 1..16).
REQ-002 The block SHALL have in_CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have in_RSTN, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have in_VALID, input, 1, request valid.
REQ-005 The block SHALL have out_READY, output, 1, block can accept a request.
REQ-006 The block SHALL have in_A and in_B, input, 64*N_WORDS each, operands.
REQ-007 The block SHALL have in_CI, input, 1, carry-in for word 0.
REQ-008 The block SHALL have in_SUB, input, 1, which selects A-B when 1 and A+B+CI when 0.
REQ-009 The block SHALL have out_VALID, output, 1, result valid.
REQ-010 The block SHALL have in_READY, input, 1, consumer accepts result.
REQ-011 The block SHALL have out_S, output, 64*N_WORDS, sum/difference.
REQ-012 The block SHALL have out_CO, output, 1, carry-out of the top word.
REQ-013 The block SHALL have out_OVF, output, 1, two's-complement signed overflow.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; out_READY SHALL equal (state==IDLE).
REQ-015 Accept: on an edge with in_VALID=1 in IDLE, the block SHALL capture A, B (B inverted if in_SUB) and carry-in (1 if in_SUB, else in_CI), clear word counter k=0, and enter RUN.
REQ-016 RUN: each cycle the single 64-bit adder SHALL add word k of the A and B' operands plus the carry register; word k of the sum SHALL be stored and the carry register updated at the edge; k SHALL increment.
REQ-017 After the edge storing word N_WORDS-1, the block SHALL enter DONE with out_VALID=1.
REQ-018 Latency SHALL be exactly N_WORDS edges from the accept edge to out_VALID=1.
REQ-019 out_CO SHALL equal the final carry register.
REQ-020 out_OVF SHALL equal (A_msb==B'_msb) AND (S_msb!=A_msb).
REQ-021 out_S, out_CO and out_OVF SHALL remain stable while out_VALID=1 and in_READY=0.
REQ-022 DONE with in_READY=1 SHALL return to IDLE at that edge; there is no same-cycle re-accept, so throughput is one request per N_WORDS+2 cycles.
REQ-023 in_VALID while in RUN or DONE SHALL be ignored, with operands not sampled.
REQ-024 Input changes after the accept edge SHALL NOT affect the result.
REQ-025 With N_WORDS=1, RUN SHALL last exactly one cycle.
REQ-026 Counter wrap SHALL NOT occur; k SHALL be ceil(log2(N_WORDS+1)) bits wide and SHALL be cleared on accept.
REQ-027 out_S and out_CO SHALL follow modulo 2^(64*N_WORDS) arithmetic.

Reset
REQ-028 With in_RSTN=0 at an edge: state SHALL be IDLE, k=0, carry=0, out_VALID=0, out_S=0, out_CO=0 and out_OVF=0; out_READY SHALL be 1 from the first cycle after reset release.
REQ-029 Reset during RUN or DONE SHALL abort the operation and discard the result; no out_VALID SHALL be produced for it.

Structure
REQ-030 State encodings and the constant WORD_W=64 SHALL live in the shared package vadd_pkg.
REQ-031 The datapath SHALL be exactly one instance of the existing 64-bit ripple-carry adder VRCA_64; no second adder SHALL be used.
REQ-032 Word select and sum placement SHALL be register-indexed muxing; there SHALL be no combinational path from inputs to outputs.

Verification (N_WORDS=2 unless noted)
REQ-033 Add with cross-word carry: A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1, CI=0 -> out_S=0x1_0000_0000_0000_0000, CO=0, OVF=0, out_VALID exactly 2 edges after accept.
REQ-034 Subtract: A=0, B=1, SUB=1 -> out_S=all ones, CO=0, OVF=0; A=0x8000...0 (MSB only), B=1, SUB=1 -> out_S=0x7FFF...F, OVF=1, CO=1.
REQ-035 Backpressure: hold in_READY=0 for 5 cycles in DONE while toggling in_VALID and in_A -> outputs stable, out_READY=0; release -> IDLE next cycle.
REQ-036 Reset mid-RUN: assert in_RSTN=0 after word 0 -> all outputs zero, out_READY=1 after release, and a following request gives a correct result.
REQ-037 N_WORDS=1 plus random: A=B=0xFFFF_FFFF_FFFF_FFFF, CI=1 -> S=0xFFFF_FFFF_FFFF_FFFF, CO=1, latency 1; then 1000 random transactions with random valid/ready gaps checked against a reference model.
